// File: rtl/cnn_pool_stream_pkg.sv
// Shared geometry, widths and FSM state type for the pooled-output streamer.
// Pooled width/height and the counter widths are derived here from the conv geometry.
package cnn_pool_stream_pkg;

  localparam int OCH      = 2;
  localparam int OX       = 4;
  localparam int OY       = 4;
  localparam int DATA_LEN = 8;

  // An odd last column/row is dropped by the integer division.
  localparam int PX  = OX / 2;
  localparam int PY  = OY / 2;
  localparam int PXW = (PX > 1) ? $clog2(PX) : 1;
  localparam int PYW = (PY > 1) ? $clog2(PY) : 1;

  localparam int FMAP_W = OCH * OX * OY * DATA_LEN;
  localparam int PIX_W  = OCH * DATA_LEN;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bit offset of element (c,y,x) inside the packed fmap.
  function automatic int elem_off(input int c, input int y, input int x);
    return ((c * OY + y) * OX + x) * DATA_LEN;
  endfunction

endpackage

// File: rtl/cnn_max4.sv
// Combinational signed max of four operands for one 2x2 pooling window.
// With CNN_POOL_RELU_EN defined, each operand is clamped at zero first.
module cnn_max4
  import cnn_pool_stream_pkg::*;
(
  input  logic signed [DATA_LEN-1:0] a,
  input  logic signed [DATA_LEN-1:0] b,
  input  logic signed [DATA_LEN-1:0] c,
  input  logic signed [DATA_LEN-1:0] d,
  output logic signed [DATA_LEN-1:0] y
);

  logic signed [DATA_LEN-1:0] ra, rb, rc, rd;
  logic signed [DATA_LEN-1:0] m0, m1;

`ifdef CNN_POOL_RELU_EN
  assign ra = a[DATA_LEN-1] ? '0 : a;
  assign rb = b[DATA_LEN-1] ? '0 : b;
  assign rc = c[DATA_LEN-1] ? '0 : c;
  assign rd = d[DATA_LEN-1] ? '0 : d;
`else
  assign ra = a;
  assign rb = b;
  assign rc = c;
  assign rd = d;
`endif

  assign m0 = (ra > rb) ? ra : rb;
  assign m1 = (rc > rd) ? rc : rd;
  assign y  = (m0 > m1) ? m0 : m1;

endmodule

// File: rtl/cnn_pool_stream.sv
// Captures one conv fmap, 2x2/stride-2 max-pools it (ReLU under CNN_POOL_RELU_EN)
// and streams pooled pixels in raster order over a valid/ready output.
module cnn_pool_stream
  import cnn_pool_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  input  logic [FMAP_W-1:0] i_in_fmap,
  output logic              o_in_ready,
  output logic              o_ot_valid,
  input  logic              i_ot_ready,
  output logic [PIX_W-1:0]  o_ot_pix,
  output logic              o_ot_last,
  output logic              o_overrun,
  output state_e            o_dbg_state
);

  // Output handshake: a beat transfers on a rising edge where o_ot_valid and
  // i_ot_ready are both high; while valid is high and ready low, pix/last hold.

  state_e            state;
  logic [FMAP_W-1:0] fmap_q;
  logic [PXW-1:0]    px, sel_px;
  logic [PYW-1:0]    py, sel_py;
  logic              sel_last;
  logic [PIX_W-1:0]  pool_pix;

  // (px,py) names the pixel in the output register; sel_* is the next one to load.
  always_comb begin
    sel_px = px;
    sel_py = py;
    if (o_ot_valid) begin
      if (px == PXW'(PX - 1)) begin
        sel_px = '0;
        sel_py = py + PYW'(1);
      end else begin
        sel_px = px + PXW'(1);
      end
    end
    sel_last = (sel_px == PXW'(PX - 1)) && (sel_py == PYW'(PY - 1));
  end

  for (genvar c = 0; c < OCH; c++) begin : g_ch
    logic signed [DATA_LEN-1:0] w00, w01, w10, w11;
    always_comb begin
      w00 = fmap_q[elem_off(c, 2 * int'(sel_py),     2 * int'(sel_px))     +: DATA_LEN];
      w01 = fmap_q[elem_off(c, 2 * int'(sel_py),     2 * int'(sel_px) + 1) +: DATA_LEN];
      w10 = fmap_q[elem_off(c, 2 * int'(sel_py) + 1, 2 * int'(sel_px))     +: DATA_LEN];
      w11 = fmap_q[elem_off(c, 2 * int'(sel_py) + 1, 2 * int'(sel_px) + 1) +: DATA_LEN];
    end
    cnn_max4 u_max4 (
      .a (w00),
      .b (w01),
      .c (w10),
      .d (w11),
      .y (pool_pix[c*DATA_LEN +: DATA_LEN])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fmap_q     <= '0;
      px         <= '0;
      py         <= '0;
      o_ot_valid <= 1'b0;
      o_ot_pix   <= '0;
      o_ot_last  <= 1'b0;
      o_overrun  <= 1'b0;
      o_in_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_in_valid) begin
            fmap_q     <= i_in_fmap;
            px         <= '0;
            py         <= '0;
            o_in_ready <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_in_valid) o_overrun <= 1'b1;
          if (!o_ot_valid || i_ot_ready) begin
            if (o_ot_valid && o_ot_last) begin
              o_ot_valid <= 1'b0;
              o_in_ready <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              px         <= sel_px;
              py         <= sel_py;
              o_ot_pix   <= pool_pix;
              o_ot_last  <= sel_last;
              o_ot_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_cnn_pool_stream.sv
// Directed bench for cnn_pool_stream: capture latency, pooling values, ReLU build option,
// backpressure, overrun, mid-stream reset and back-to-back frames.
module tb_cnn_pool_stream;
  import cnn_pool_stream_pkg::*;

  localparam int W  = PIX_W;
  localparam int FW = FMAP_W;

`ifdef CNN_POOL_RELU_EN
  localparam logic [7:0] T2_CH0 = 8'h00;
  localparam logic [7:0] NEG16  = 8'h00;
`else
  localparam logic [7:0] T2_CH0 = 8'hFF;
  localparam logic [7:0] NEG16  = 8'hF0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_in_valid;
  logic [FW-1:0] i_in_fmap;
  logic          o_in_ready;
  logic          o_ot_valid;
  logic          i_ot_ready;
  logic [W-1:0]  o_ot_pix;
  logic          o_ot_last;
  logic          o_overrun;
  state_e        o_dbg_state;

  cnn_pool_stream dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .i_in_fmap   (i_in_fmap),
    .o_in_ready  (o_in_ready),
    .o_ot_valid  (o_ot_valid),
    .i_ot_ready  (i_ot_ready),
    .o_ot_pix    (o_ot_pix),
    .o_ot_last   (o_ot_last),
    .o_overrun   (o_overrun),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_pix[16];
  logic          got_last[16];
  int            got_cyc[16];
  int            got_n;
  int            stall_bad;
  int            first_valid_cyc;
  logic [FW-1:0] fm;
  logic [FW-1:0] fm_t1;
  logic [FW-1:0] inj_fmap;

  task automatic set_el(input int c, input int y, input int x, input logic [7:0] v);
    fm[((c * OY + y) * OX + x) * DATA_LEN +: DATA_LEN] = v;
  endtask

  task automatic build_t1();
    fm = '0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        set_el(0, y, x, 8'(y * 4 + x));
        set_el(1, y, x, 8'h05);
      end
    fm_t1 = fm;
  endtask

  task automatic send_fmap(input logic [FW-1:0] f);
    i_in_valid = 1'b1;
    i_in_fmap  = f;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic collect(input int mode, input int max_cyc, input int inj_cyc);
    logic [W-1:0] held_pix;
    logic         held_last;
    logic         stalled;
    got_n = 0; stall_bad = 0; first_valid_cyc = -1; stalled = 1'b0;
    held_pix = '0; held_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got_pix[i] = 'x; got_last[i] = 1'bx; got_cyc[i] = -1;
    end
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(posedge clk); #1;
      if (o_ot_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled && (!o_ot_valid || o_ot_pix !== held_pix || o_ot_last !== held_last))
        stall_bad++;
      i_ot_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      i_in_valid = (cyc == inj_cyc);
      if (cyc == inj_cyc) i_in_fmap = inj_fmap;
      if (o_ot_valid && i_ot_ready) begin
        got_pix[got_n]  = o_ot_pix;
        got_last[got_n] = o_ot_last;
        got_cyc[got_n]  = cyc;
        got_n++;
        stalled = 1'b0;
        if (o_ot_last || got_n == 16) return;
      end else if (o_ot_valid) begin
        stalled   = 1'b1;
        held_pix  = o_ot_pix;
        held_last = o_ot_last;
      end
    end
  endtask

  task automatic push_t1_exp();
    exp_q.push_back(16'h0505);
    exp_q.push_back(16'h0507);
    exp_q.push_back(16'h050D);
    exp_q.push_back(16'h050F);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_in_valid = 1'b1; i_in_fmap = '1; i_ot_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (o_in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", o_in_ready); else n_pass++;
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", o_ot_valid); else n_pass++;
    n_checks++; if (o_ot_pix !== '0) $display("FAIL rst_pix got=%h exp=0", o_ot_pix); else n_pass++;
    n_checks++; if (o_ot_last !== 1'b0) $display("FAIL rst_last got=%b exp=0", o_ot_last); else n_pass++;
    n_checks++; if (o_overrun !== 1'b0) $display("FAIL rst_overrun got=%b exp=0", o_overrun); else n_pass++;
    n_checks++; if (o_dbg_state !== ST_IDLE) $display("FAIL rst_state got=%0d exp=0", o_dbg_state); else n_pass++;
    reset = 1'b0; i_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL rst_nocapture got=%b exp=0", o_ot_valid); else n_pass++;
  endtask

  task automatic test_basic();
    build_t1();
    i_ot_ready = 1'b1;
    send_fmap(fm_t1);
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL t1_lat0 got=%b exp=0", o_ot_valid); else n_pass++;
    n_checks++; if (o_in_ready !== 1'b0) $display("FAIL t1_busy got=%b exp=0", o_in_ready); else n_pass++;
    collect(0, 20, -1);
    push_t1_exp();
    n_checks++; if (first_valid_cyc !== 0) $display("FAIL t1_first_valid got=%0d exp=0", first_valid_cyc); else n_pass++;
    n_checks++; if (got_n !== 4) $display("FAIL t1_beats got=%0d exp=4", got_n); else n_pass++;
    n_checks++; if (got_cyc[3] - got_cyc[0] !== 3) $display("FAIL t1_no_bubble got=%0d exp=3", got_cyc[3] - got_cyc[0]); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_pix[i] !== e) $display("FAIL t1_pix%0d got=%h exp=%h", i, got_pix[i], e); else n_pass++;
      n_checks++; if (got_last[i] !== (i == 3)) $display("FAIL t1_last%0d got=%b exp=%b", i, got_last[i], i == 3); else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL t1_valid_drop got=%b exp=0", o_ot_valid); else n_pass++;
    n_checks++; if (o_in_ready !== 1'b1) $display("FAIL t1_ready_back got=%b exp=1", o_in_ready); else n_pass++;
  endtask

  task automatic test_relu();
    fm = '0;
    set_el(0, 0, 0, 8'hFD);
    set_el(0, 0, 1, 8'hF8);
    set_el(0, 1, 0, 8'hFF);
    set_el(0, 1, 1, 8'h80);
    send_fmap(fm);
    collect(0, 20, -1);
    exp_q.push_back({8'h00, T2_CH0});
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    n_checks++; if (got_n !== 4) $display("FAIL t2_beats got=%0d exp=4", got_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_pix[i] !== e) $display("FAIL t2_pix%0d got=%h exp=%h", i, got_pix[i], e); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    send_fmap(fm_t1);
    collect(1, 40, -1);
    push_t1_exp();
    n_checks++; if (got_n !== 4) $display("FAIL t3_beats got=%0d exp=4", got_n); else n_pass++;
    n_checks++; if (stall_bad !== 0) $display("FAIL t3_stall_stable got=%0d exp=0", stall_bad); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_pix[i] !== e) $display("FAIL t3_pix%0d got=%h exp=%h", i, got_pix[i], e); else n_pass++;
      n_checks++; if (got_last[i] !== (i == 3)) $display("FAIL t3_last%0d got=%b exp=%b", i, got_last[i], i == 3); else n_pass++;
    end
    i_ot_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    inj_fmap = '1;
    send_fmap(fm_t1);
    collect(0, 20, 2);
    i_in_valid = 1'b0;
    push_t1_exp();
    n_checks++; if (got_n !== 4) $display("FAIL t4_beats got=%0d exp=4", got_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_pix[i] !== e) $display("FAIL t4_pix%0d got=%h exp=%h", i, got_pix[i], e); else n_pass++;
    end
    n_checks++; if (o_overrun !== 1'b1) $display("FAIL t4_overrun got=%b exp=1", o_overrun); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_in_ready !== 1'b1) $display("FAIL t4_ready_back got=%b exp=1", o_in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL t4_no_extra_frame got=%b exp=0", o_ot_valid); else n_pass++;
  endtask

  task automatic test_mid_reset();
    i_ot_ready = 1'b1;
    send_fmap(fm_t1);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (o_ot_pix !== 16'h050D) $display("FAIL t5_beat2 got=%h exp=050d", o_ot_pix); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL t5_valid got=%b exp=0", o_ot_valid); else n_pass++;
    n_checks++; if (o_in_ready !== 1'b1) $display("FAIL t5_in_ready got=%b exp=1", o_in_ready); else n_pass++;
    n_checks++; if (o_overrun !== 1'b0) $display("FAIL t5_overrun got=%b exp=0", o_overrun); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_ot_valid !== 1'b0) $display("FAIL t5_aborted got=%b exp=0", o_ot_valid); else n_pass++;
    send_fmap(fm_t1);
    collect(0, 20, -1);
    push_t1_exp();
    n_checks++; if (got_n !== 4) $display("FAIL t5_beats got=%0d exp=4", got_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_pix[i] !== e) $display("FAIL t5_pix%0d got=%h exp=%h", i, got_pix[i], e); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int total;
    logic [FW-1:0] f2;
    fm = '0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        set_el(0, y, x, 8'(15 - (y * 4 + x)));
        set_el(1, y, x, 8'hF0);
      end
    f2 = fm;
    i_ot_ready = 1'b1;
    send_fmap(fm_t1);
    collect(0, 20, -1);
    total = got_n;
    @(posedge clk); #1;
    n_checks++; if (o_in_ready !== 1'b1) $display("FAIL t6_ready_gap got=%b exp=1", o_in_ready); else n_pass++;
    send_fmap(f2);
    collect(0, 20, -1);
    total += got_n;
    exp_q.push_back({NEG16, 8'd15});
    exp_q.push_back({NEG16, 8'd13});
    exp_q.push_back({NEG16, 8'd7});
    exp_q.push_back({NEG16, 8'd5});
    n_checks++; if (total !== 8) $display("FAIL t6_total_beats got=%0d exp=8", total); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_pix[i] !== e) $display("FAIL t6_pix%0d got=%h exp=%h", i, got_pix[i], e); else n_pass++;
    end
    n_checks++; if (o_overrun !== 1'b0) $display("FAIL t6_overrun got=%b exp=0", o_overrun); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; i_in_valid = 1'b0; i_in_fmap = '0; i_ot_ready = 1'b0;
    fm = '0; fm_t1 = '0; inj_fmap = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
